// File: rtl/piradip_r2s_pkg.sv
// Shared constants and register-decode helpers for the multi-channel register-to-stream block.
// Latency: none (package only).
// Backpressure: n/a.
// Contents: status bit positions, register-number decode functions.
// Optional feature macro used by the block: PIRADIP_R2S_TLAST_EN.
package piradip_r2s_pkg;

  localparam int STAT_NOT_FULL  = 0;
  localparam int STAT_OVF       = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_LAST_PEND = 3;
  localparam int STAT_COUNT_LSB = 8;

  // Registers are laid out in pairs from base: even offset = data, odd offset = status.
  function automatic bit in_map(input int unsigned regno, input int unsigned base,
                                input int unsigned num_ch);
    return (regno >= base) && (regno < base + 2 * num_ch);
  endfunction

  function automatic bit is_data_reg(input int unsigned regno, input int unsigned base,
                                     input int unsigned num_ch);
    return in_map(regno, base, num_ch) && (((regno - base) & 32'd1) == 32'd0);
  endfunction

  function automatic bit is_stat_reg(input int unsigned regno, input int unsigned base,
                                     input int unsigned num_ch);
    return in_map(regno, base, num_ch) && (((regno - base) & 32'd1) == 32'd1);
  endfunction

  // Only meaningful once the number is known to be inside the map.
  function automatic int regno_to_ch(input int unsigned regno, input int unsigned base);
    return int'((regno - base) >> 1);
  endfunction

endpackage

// File: rtl/piradip_r2s_fifo.sv
// Single-channel synchronous FIFO with occupancy count; head word is read combinationally.
// Latency: a push at edge N is visible at the head from cycle N+1 (no bypass when empty).
// Backpressure: a push while full is accepted only if a pop happens in the same cycle; push_ok reports acceptance.
// Ports: clk/rst (sync, active-high); push/push_data; pop; head_data; full/empty/count; push_ok.
module piradip_r2s_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/piradip_register_to_stream_mc.sv
// Multi-channel register-to-stream issuer: data-register writes queue words per channel, drained on AXI4-Stream.
// Latency: word written at edge N is offered on m_tvalid/m_tdata in cycle N+1.
// Backpressure: up to FIFO_DEPTH words absorbed per channel; further writes are dropped and set a sticky overflow flag.
// Ports: aclk, areset (sync, active-high); register write (wren, wreg_no, wreg_data, wstrb);
//        register read (rden, rreg_no, rreg_data comb); per-channel stream m_tdata/m_tvalid/m_tready/m_tlast.
// Optional: define PIRADIP_R2S_TLAST_EN to enable per-channel tlast marking via status-register writes.
module piradip_register_to_stream_mc
  import piradip_r2s_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int REGISTER_ADDR_BITS = 8,
  parameter int NUM_CH             = 4,
  parameter int FIFO_DEPTH         = 8,
  parameter int REG_BASE           = 0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           wren,
  input  logic [REGISTER_ADDR_BITS-1:0]  wreg_no,
  input  logic [DATA_WIDTH-1:0]          wreg_data,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           rden,
  input  logic [REGISTER_ADDR_BITS-1:0]  rreg_no,
  output logic [DATA_WIDTH-1:0]          rreg_data,
  output logic [NUM_CH*DATA_WIDTH-1:0]   m_tdata,
  output logic [NUM_CH-1:0]              m_tvalid,
  input  logic [NUM_CH-1:0]              m_tready,
  output logic [NUM_CH-1:0]              m_tlast
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef PIRADIP_R2S_TLAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  logic [DATA_WIDTH-1:0] wdata_masked;
  logic [DATA_WIDTH-1:0] stat_vec [NUM_CH];
  logic [NUM_CH-1:0]     rd_stat_hit;

  always_comb begin
    wdata_masked = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wstrb[b]) wdata_masked[b*8 +: 8] = wreg_data[b*8 +: 8];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             wr_data_hit;
    logic             push_ok;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [FW-1:0]    push_word;
    logic [FW-1:0]    head;
    logic             ovf;
    logic [7:0]       cnt8;

    assign wr_data_hit = wren
                         && is_data_reg(32'(wreg_no), REG_BASE, NUM_CH)
                         && (regno_to_ch(32'(wreg_no), REG_BASE) == c);
    assign rd_stat_hit[c] = is_stat_reg(32'(rreg_no), REG_BASE, NUM_CH)
                            && (regno_to_ch(32'(rreg_no), REG_BASE) == c);

`ifdef PIRADIP_R2S_TLAST_EN
    logic wr_stat_hit;
    logic last_pending;

    assign wr_stat_hit = wren
                         && is_stat_reg(32'(wreg_no), REG_BASE, NUM_CH)
                         && (regno_to_ch(32'(wreg_no), REG_BASE) == c);
    assign push_word = {last_pending, wdata_masked};

    // Arm and push cannot coincide (single write port), so no priority question arises.
    always_ff @(posedge aclk) begin
      if (areset) begin
        last_pending <= 1'b0;
      end else if (wr_stat_hit && wstrb[0] && wreg_data[0]) begin
        last_pending <= 1'b1;
      end else if (push_ok) begin
        last_pending <= 1'b0;
      end
    end

    // Mask with !empty so a stale entry never shows tlast while the channel is idle.
    assign m_tlast[c] = !empty && head[DATA_WIDTH];
`else
    assign push_word  = wdata_masked;
    assign m_tlast[c] = 1'b0;
`endif

    piradip_r2s_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (aclk),
      .rst       (areset),
      .push      (wr_data_hit),
      .push_data (push_word),
      .pop       (m_tready[c]),
      .head_data (head),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .push_ok   (push_ok)
    );

    assign m_tvalid[c]                       = !empty;
    assign m_tdata[c*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];

    // A new overflow wins over a read-clear in the same cycle.
    always_ff @(posedge aclk) begin
      if (areset) begin
        ovf <= 1'b0;
      end else if (wr_data_hit && !push_ok) begin
        ovf <= 1'b1;
      end else if (rden && rd_stat_hit[c]) begin
        ovf <= 1'b0;
      end
    end

    assign cnt8 = 8'(count);

    always_comb begin
      stat_vec[c]                          = '0;
      stat_vec[c][STAT_NOT_FULL]           = !full;
      stat_vec[c][STAT_OVF]                = ovf;
      stat_vec[c][STAT_EMPTY]              = empty;
`ifdef PIRADIP_R2S_TLAST_EN
      stat_vec[c][STAT_LAST_PEND]          = last_pending;
`endif
      stat_vec[c][STAT_COUNT_LSB +: 8]     = cnt8;
    end
  end

  // Data registers and unmapped numbers read as zero.
  always_comb begin
    rreg_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_stat_hit[c]) rreg_data = stat_vec[c];
    end
  end

endmodule

// File: tb/tb_piradip_register_to_stream_mc.sv
// Directed self-checking bench for piradip_register_to_stream_mc (defaults: 32-bit, 4 channels, depth 8).
// Inputs change 1 time unit after the rising edge; outputs are sampled away from the edge.
module tb_piradip_register_to_stream_mc;

  logic        aclk = 1'b0;
  logic        areset;
  logic        wren;
  logic [7:0]  wreg_no;
  logic [31:0] wreg_data;
  logic [3:0]  wstrb;
  logic        rden;
  logic [7:0]  rreg_no;
  logic [31:0] rreg_data;
  logic [127:0] m_tdata;
  logic [3:0]  m_tvalid;
  logic [3:0]  m_tready;
  logic [3:0]  m_tlast;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  piradip_register_to_stream_mc dut (
    .aclk      (aclk),
    .areset    (areset),
    .wren      (wren),
    .wreg_no   (wreg_no),
    .wreg_data (wreg_data),
    .wstrb     (wstrb),
    .rden      (rden),
    .rreg_no   (rreg_no),
    .rreg_data (rreg_data),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] no, input logic [31:0] data, input logic [3:0] strb);
    wren = 1'b1; wreg_no = no; wreg_data = data; wstrb = strb;
    tick();
    wren = 1'b0;
  endtask

  // Samples the combinational read value, then lets rden cross one edge (clears overflow).
  task automatic rd(input logic [7:0] no, output logic [31:0] data);
    rreg_no = no; rden = 1'b1;
    #1;
    data = rreg_data;
    tick();
    rden = 1'b0;
  endtask

  function automatic logic [31:0] ch_data(input logic [127:0] bus, input int c);
    return bus[c*32 +: 32];
  endfunction

  logic [31:0] r;

  initial begin
    areset = 1'b1; wren = 1'b0; wreg_no = '0; wreg_data = '0; wstrb = '0;
    rden = 1'b0; rreg_no = '0; m_tready = 4'b0000;
    tick(); tick();
    areset = 1'b0;

    // Reset state
    check("rst_tvalid", 32'(m_tvalid), 32'h0);
    check("rst_tlast", 32'(m_tlast), 32'h0);
    rd(8'd1, r); check("rst_status0", r, 32'h0000_0005);

    // 1: single word through channel 0
    m_tready = 4'b1101;
    wr(8'd0, 32'hDEAD_BEEF, 4'hF);
    check("t1_tvalid", 32'(m_tvalid[0]), 32'h1);
    check("t1_tdata", ch_data(m_tdata, 0), 32'hDEAD_BEEF);
    tick();
    check("t1_drained", 32'(m_tvalid[0]), 32'h0);
    rd(8'd1, r); check("t1_status0", r, 32'h0000_0005);

    // 2: overflow on stalled channel 1, then drain in order
    for (int k = 1; k <= 10; k++) wr(8'd2, 32'(k), 4'hF);
    rd(8'd3, r); check("t2_status_full_ovf", r, 32'h0000_0802);
    m_tready[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t2_vld%0d", k), 32'(m_tvalid[1]), 32'h1);
      check($sformatf("t2_dat%0d", k), ch_data(m_tdata, 1), 32'(k));
      tick();
    end
    check("t2_empty", 32'(m_tvalid[1]), 32'h0);
    rd(8'd3, r); check("t2_ovf_cleared", r, 32'h0000_0005);

    // 3: push into a full FIFO with a simultaneous pop
    m_tready[1] = 1'b0;
    for (int k = 11; k <= 18; k++) wr(8'd2, 32'(k), 4'hF);
    m_tready[1] = 1'b1;
    wr(8'd2, 32'd19, 4'hF);
    m_tready[1] = 1'b0;
    rd(8'd3, r); check("t3_status_full_no_ovf", r, 32'h0000_0800);
    m_tready[1] = 1'b1;
    for (int k = 12; k <= 19; k++) begin
      check($sformatf("t3_dat%0d", k), ch_data(m_tdata, 1), 32'(k));
      tick();
    end
    rd(8'd3, r); check("t3_status_after", r, 32'h0000_0005);

    // 4: byte strobes zero unstrobed bytes
    wr(8'd4, 32'hAABB_CCDD, 4'b0011);
    check("t4_tvalid", 32'(m_tvalid[2]), 32'h1);
    check("t4_tdata", ch_data(m_tdata, 2), 32'h0000_CCDD);
    tick();

    // Map edges: out-of-range number and data register read as 0; out-of-range write goes nowhere
    wr(8'd8, 32'h1234_5678, 4'hF);
    check("map_oob_write", 32'(m_tvalid), 32'h0);
    rd(8'd8, r); check("map_oob_read", r, 32'h0);

    // 5: stalled channel 0 does not block channel 3; mid-transfer reset
    m_tready = 4'b1000;
    wr(8'd0, 32'hA1, 4'hF);
    wr(8'd0, 32'hA2, 4'hF);
    wr(8'd0, 32'hA3, 4'hF);
    rd(8'd1, r); check("t5_status0_cnt3", r, 32'h0000_0301);
    rd(8'd0, r); check("t5_data_reg_read", r, 32'h0);
    wr(8'd6, 32'h33, 4'hF);
    check("t5_ch3_dat", ch_data(m_tdata, 3), 32'h33);
    check("t5_ch0_head", ch_data(m_tdata, 0), 32'hA1);
    tick();
    wr(8'd6, 32'h44, 4'hF);
    check("t5_ch3_dat2", ch_data(m_tdata, 3), 32'h44);
    m_tready = 4'b0000;
    tick();
    wr(8'd6, 32'h55, 4'hF);
    check("t5_pre_reset_vld", 32'(m_tvalid), 32'h9);
    // reset with a coincident write that must be discarded
    areset = 1'b1;
    wr(8'd4, 32'h66, 4'hF);
    areset = 1'b0;
    check("t5_reset_tvalid", 32'(m_tvalid), 32'h0);
    check("t5_reset_tlast", 32'(m_tlast), 32'h0);
    for (int c = 0; c < 4; c++) begin
      rd(8'(2 * c + 1), r);
      check($sformatf("t5_reset_status%0d", c), r, 32'h0000_0005);
    end

`ifdef PIRADIP_R2S_TLAST_EN
    // 6: tlast marking
    m_tready[0] = 1'b0;
    wr(8'd1, 32'h1, 4'h1);
    rd(8'd1, r); check("t6_armed", r, 32'h0000_000D);
    wr(8'd0, 32'h11, 4'hF);
    rd(8'd1, r); check("t6_disarmed", r, 32'h0000_0101);
    wr(8'd0, 32'h22, 4'hF);
    m_tready[0] = 1'b1;
    check("t6_dat1", ch_data(m_tdata, 0), 32'h11);
    check("t6_last1", 32'(m_tlast[0]), 32'h1);
    tick();
    check("t6_dat2", ch_data(m_tdata, 0), 32'h22);
    check("t6_last2", 32'(m_tlast[0]), 32'h0);
    tick();
`else
    // Without the tlast feature, status writes do nothing and tlast stays low
    wr(8'd1, 32'h1, 4'h1);
    rd(8'd1, r); check("t6_stat_write_ignored", r, 32'h0000_0005);
    m_tready[0] = 1'b0;
    wr(8'd0, 32'h11, 4'hF);
    check("t6_tlast_low", 32'(m_tlast), 32'h0);
    check("t6_dat", ch_data(m_tdata, 0), 32'h11);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
